// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main sequencer: steps fetch/decode/execute/memory/writeback and counts retires.
// Optional MEM_WAIT_EN adds a mem_ready handshake that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_control_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic [2:0]       ALU_flags,
`ifdef MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       ImmSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ALU_op,
   output logic [1:0]       Result_src,
   output logic             illegal_instr,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StJal      = 4'd10
   } state_t;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_count;
   logic             w_ready;
   logic             w_retire;
   logic             w_taken;

`ifdef MEM_WAIT_EN
   assign w_ready = mem_ready;
`else
   assign w_ready = 1'b1;
`endif

   // An instruction retires on the edge that returns its final state to FETCH
   assign w_retire = (r_state == StMemWb) || (r_state == StAluWb) || (r_state == StBranch) ||
                     ((r_state == StMemWrite) && w_ready);

   assign state       = r_state;
   assign instr_count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StFetch;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_count <= r_count + 1'b1;
      end
   end

   always_comb begin
      w_next = StFetch;
      case (r_state)
         StFetch:    w_next = w_ready ? StDecode : StFetch;
         StDecode: begin
            case (opcode)
               OpLoad, OpStore: w_next = StMemAdr;
               OpRType:         w_next = StExecR;
               OpIType:         w_next = StExecI;
               OpBranch:        w_next = StBranch;
               OpJal:           w_next = StJal;
               default:         w_next = StFetch;
            endcase
         end
         StMemAdr:   w_next = (opcode == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:  w_next = w_ready ? StMemWb : StMemRead;
         StMemWrite: w_next = w_ready ? StFetch : StMemWrite;
         StExecR:    w_next = StAluWb;
         StExecI:    w_next = StAluWb;
         StJal:      w_next = StAluWb;
         default:    w_next = StFetch;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  w_taken = ALU_flags[0];
         3'b001:  w_taken = !ALU_flags[0];
         3'b100:  w_taken = ALU_flags[1] ^ ALU_flags[2];
         3'b101:  w_taken = !(ALU_flags[1] ^ ALU_flags[2]);
         default: w_taken = 1'b0;
      endcase
   end

   always_comb begin
      PCWrite       = 1'b0;
      AdrSrc        = 1'b0;
      IRWrite       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ALU_op        = 3'b000;
      Result_src    = 2'b00;
      illegal_instr = 1'b0;
      case (opcode)
         OpStore:  ImmSrc = 2'b01;
         OpBranch: ImmSrc = 2'b10;
         OpJal:    ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
      case (r_state)
         StFetch: begin
            IRWrite    = w_ready;
            PCWrite    = w_ready;
            ALUSrcB    = 2'b10;
            Result_src = 2'b10;
         end
         StDecode: begin
            ALUSrcA       = 2'b01;
            ALUSrcB       = 2'b01;
            illegal_instr = !(opcode inside {OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal});
         end
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         StMemRead:  AdrSrc = 1'b1;
         StMemWb: begin
            Result_src = 2'b01;
            RegWrite   = 1'b1;
         end
         StMemWrite: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            ALU_op  = 3'b111;
         end
         StExecI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALU_op  = 3'b111;
         end
         StAluWb:    RegWrite = 1'b1;
         StBranch: begin
            ALUSrcA = 2'b10;
            ALU_op  = 3'b001;
            PCWrite = w_taken;
         end
         StJal: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // Reset forces every output low, including the opcode-decoded ImmSrc
      if (reset) begin
         PCWrite       = 1'b0;
         AdrSrc        = 1'b0;
         IRWrite       = 1'b0;
         MemWrite      = 1'b0;
         RegWrite      = 1'b0;
         ImmSrc        = 2'b00;
         ALUSrcA       = 2'b00;
         ALUSrcB       = 2'b00;
         ALU_op        = 3'b000;
         Result_src    = 2'b00;
         illegal_instr = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: instruction-level model queues per-cycle expectations.
// Build with MEM_WAIT_EN defined to also exercise random memory wait cycles.
module tb_multicycle_control_fsm;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [6:0]    opcode = 7'd0;
   logic [2:0]    funct3 = 3'd0;
   logic [2:0]    ALU_flags = 3'd0;
   logic          mem_ready = 1'b1;
   logic          PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal_instr;
   logic [1:0]    ImmSrc, ALUSrcA, ALUSrcB, Result_src;
   logic [2:0]    ALU_op;
   logic [3:0]    state;
   logic [CW-1:0] instr_count;

   multicycle_control_fsm #(.CNT_W(CW)) dut (
      .clk(clk),
      .reset(reset),
      .opcode(opcode),
      .funct3(funct3),
      .ALU_flags(ALU_flags),
`ifdef MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .PCWrite(PCWrite),
      .AdrSrc(AdrSrc),
      .IRWrite(IRWrite),
      .MemWrite(MemWrite),
      .RegWrite(RegWrite),
      .ImmSrc(ImmSrc),
      .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB),
      .ALU_op(ALU_op),
      .Result_src(Result_src),
      .illegal_instr(illegal_instr),
      .state(state),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [20:0]   outs;
      logic [CW-1:0] cnt;
   } rec_t;

   rec_t          sb_q[$];
   rec_t          mon_e;
   logic [20:0]   mon_act;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [CW-1:0] m_count = '0;

   function automatic logic is_legal(logic [6:0] op);
      return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
             op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
   endfunction

   function automatic logic branch_taken(logic [2:0] f3, logic [2:0] fl);
      logic z, lt;
      z  = fl[0];
      lt = fl[1] ^ fl[2];
      if (f3 == 3'b000) return z;
      if (f3 == 3'b001) return !z;
      if (f3 == 3'b100) return lt;
      if (f3 == 3'b101) return !lt;
      return 1'b0;
   endfunction

   // Expected output vector for one cycle spent in state s
   function automatic logic [20:0] exp_outs(int s, logic [6:0] op, logic [2:0] f3,
                                            logic [2:0] fl, logic rdy);
      logic       pcw, adr, irw, mw, rw, ill;
      logic [1:0] imm, sa, sb, rs;
      logic [2:0] aop;
      logic [3:0] st;
      pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
      sa = 0; sb = 0; rs = 0; aop = 0;
      st = s[3:0];
      imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
      case (s)
         0:  begin irw = rdy; pcw = rdy; sb = 2'b10; rs = 2'b10; end
         1:  begin sa = 2'b01; sb = 2'b01; ill = !is_legal(op); end
         2:  begin sa = 2'b10; sb = 2'b01; end
         3:  adr = 1;
         4:  begin rs = 2'b01; rw = 1; end
         5:  begin adr = 1; mw = 1; end
         6:  begin sa = 2'b10; aop = 3'b111; end
         7:  begin sa = 2'b10; sb = 2'b01; aop = 3'b111; end
         8:  rw = 1;
         9:  begin sa = 2'b10; aop = 3'b001; pcw = branch_taken(f3, fl); end
         10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
         default: ;
      endcase
      return {st, pcw, adr, irw, mw, rw, imm, sa, sb, aop, rs, ill};
   endfunction

   task automatic push_cycle(logic [20:0] o, logic rdy);
      mem_ready = rdy;
      sb_q.push_back({o, m_count});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int n);
      reset   = 1'b1;
      m_count = '0;
      repeat (n) push_cycle(21'd0, 1'b1);
      reset = 1'b0;
   endtask

   // One instruction: the state walk follows from its class and the documented latencies
   task automatic issue(logic [6:0] op, logic [2:0] f3, logic [2:0] fl, bit abort);
      int   base[$];
      int   sq[$];
      logic rq[$];
      int   cut;
      opcode = op; funct3 = f3; ALU_flags = fl;
      case (op)
         7'b0000011: base = '{0, 1, 2, 3, 4};
         7'b0100011: base = '{0, 1, 2, 5};
         7'b0110011: base = '{0, 1, 6, 8};
         7'b0010011: base = '{0, 1, 7, 8};
         7'b1100011: base = '{0, 1, 9};
         7'b1101111: base = '{0, 1, 10, 8};
         default:    base = '{0, 1};
      endcase
      foreach (base[i]) begin
`ifdef MEM_WAIT_EN
         if (base[i] == 0 || base[i] == 3 || base[i] == 5)
            repeat ($urandom_range(0, 2)) begin
               sq.push_back(base[i]);
               rq.push_back(1'b0);
            end
`endif
         sq.push_back(base[i]);
         rq.push_back(1'b1);
      end
      cut = abort ? int'($urandom_range(1, sq.size() - 1)) : sq.size();
      for (int i = 0; i < cut; i++) push_cycle(exp_outs(sq[i], op, f3, fl, rq[i]), rq[i]);
      if (abort) do_reset(2);
      else if (is_legal(op)) m_count = m_count + 1'b1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e   = sb_q.pop_front();
         mon_act = {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ImmSrc,
                    ALUSrcA, ALUSrcB, ALU_op, Result_src, illegal_instr};
         n_checks++;
         if (mon_act !== mon_e.outs) begin
            n_errors++;
            $display("FAIL outputs @%0t: got %b expected %b (st,pcw,adr,irw,mw,rw,imm,sa,sb,op,rs,ill)",
                     $time, mon_act, mon_e.outs);
         end
         n_checks++;
         if (instr_count !== mon_e.cnt) begin
            n_errors++;
            $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, mon_e.cnt);
         end
      end
   end

   logic [6:0] r_ops [0:5] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1100011, 7'b1101111};

   initial begin
      logic [6:0] op;
      int         k;
      opcode = 7'b0100011;
      @(posedge clk);
      #1;
      do_reset(3);
      issue(7'b0010011, 3'b000, 3'b000, 0);
      issue(7'b0000011, 3'b010, 3'b000, 0);
      issue(7'b0100011, 3'b010, 3'b000, 0);
      issue(7'b1100011, 3'b001, 3'b001, 0);
      issue(7'b1100011, 3'b001, 3'b000, 0);
      issue(7'b1100011, 3'b101, 3'b110, 0);
      issue(7'b1100111, 3'b000, 3'b000, 0);
      issue(7'b1101111, 3'b000, 3'b000, 0);
      issue(7'b0110011, 3'b000, 3'b000, 0);
      issue(7'b0000011, 3'b010, 3'b000, 1);
      for (int n = 0; n < 300; n++) begin
         k = int'($urandom_range(0, 8));
         if (k < 6) op = r_ops[k];
         else if (k == 6) op = 7'b1100111;
         else if (k == 7) op = 7'($urandom);
         else op = 7'b0110111;
         issue(op, 3'($urandom), 3'($urandom), (n % 37) == 36);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
